// File: rtl/pdl_pkg.sv
// Shared definitions for the PDL PUF evaluation controller, the PDL PUF and its bench.
package pdl_pkg;

  localparam int unsigned PdlWidthDefault = 64;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StSettle,
    StSample,
    StDone
  } state_e;

  function automatic bit params_legal(input int unsigned num_evals,
                                      input int unsigned reset_cycles,
                                      input int unsigned settle_cycles);
    return (num_evals >= 1) && (num_evals % 2 == 1) && (reset_cycles >= 1) &&
           (settle_cycles >= 3);
  endfunction

endpackage

// File: rtl/pdl_vote_counter.sv
// One PUF bit: 2-flop synchroniser, ones counter, majority and unanimity flags.
module pdl_vote_counter #(
  parameter int unsigned NUM_EVALS = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample,
  input  logic puf_o,
  output logic majority,
  output logic unstable
);

  localparam int unsigned CntW = $clog2(NUM_EVALS + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] ones_q;
  logic [CntW-1:0] ones_d;
  logic            majority_q;
  logic            unstable_q;

  assign ones_d = ones_q + CntW'(sync_q[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      ones_q     <= '0;
      majority_q <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], puf_o};
      if (clear) begin
        ones_q     <= '0;
        majority_q <= 1'b0;
        unstable_q <= 1'b0;
      end else if (sample) begin
        // Flags track the running count, so they are final once the last sample lands.
        ones_q     <= ones_d;
        majority_q <= (ones_d > CntW'(NUM_EVALS / 2));
        unstable_q <= (ones_d != '0) && (ones_d != CntW'(NUM_EVALS));
      end
    end
  end

  assign majority = majority_q;
  assign unstable = unstable_q;

endmodule

// File: rtl/pdl_puf_controller.sv
// Runs NUM_EVALS reset/launch/sample rounds per challenge and returns a majority-voted word.
module pdl_puf_controller
  import pdl_pkg::*;
#(
  parameter int unsigned NUM_PUF       = 16,
  parameter int unsigned PDL_WIDTH     = PdlWidthDefault,
  parameter int unsigned NUM_EVALS     = 7,
  parameter int unsigned RESET_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chal_valid,
  output logic                 chal_ready,
  input  logic [PDL_WIDTH-1:0] chal_top,
  input  logic [PDL_WIDTH-1:0] chal_bottom,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [NUM_PUF-1:0]   resp_bits,
  output logic [NUM_PUF-1:0]   resp_unstable,
  output logic [PDL_WIDTH-1:0] puf_s_tp,
  output logic [PDL_WIDTH-1:0] puf_s_btm,
  output logic                 puf_launch,
  output logic                 puf_reset,
  input  logic [NUM_PUF-1:0]   puf_o
);

  localparam int unsigned CntW   = $clog2(NUM_EVALS + 1);
  localparam int unsigned TmrMax = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  if (!params_legal(NUM_EVALS, RESET_CYCLES, SETTLE_CYCLES)) begin : g_illegal_params
    $error("pdl_puf_controller: NUM_EVALS must be odd, RESET_CYCLES>=1, SETTLE_CYCLES>=3");
  end

  state_e               state_q;
  logic [CntW-1:0]      eval_q;
  logic [CntW-1:0]      eval_nxt;
  logic [TmrW-1:0]      tmr_q;
  logic                 resp_valid_q;
  logic                 launch_q;
  logic                 puf_reset_q;
  logic [PDL_WIDTH-1:0] s_tp_q;
  logic [PDL_WIDTH-1:0] s_btm_q;
  logic                 accept;
  logic                 sample;

  assign accept   = (state_q == StIdle) && chal_valid;
  assign sample   = (state_q == StSample);
  assign eval_nxt = eval_q + CntW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      eval_q       <= '0;
      tmr_q        <= '0;
      resp_valid_q <= 1'b0;
      launch_q     <= 1'b0;
      puf_reset_q  <= 1'b1;
      s_tp_q       <= '0;
      s_btm_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (chal_valid) begin
            s_tp_q  <= chal_top;
            s_btm_q <= chal_bottom;
            eval_q  <= '0;
            tmr_q   <= '0;
            state_q <= StArm;
          end
        end
        StArm: begin
          if (tmr_q == TmrW'(RESET_CYCLES - 1)) begin
            tmr_q       <= '0;
            puf_reset_q <= 1'b0;
            launch_q    <= 1'b1;
            state_q     <= StSettle;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StSettle: begin
          if (tmr_q == TmrW'(SETTLE_CYCLES - 1)) begin
            tmr_q   <= '0;
            state_q <= StSample;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StSample: begin
          // Launch drops here so the arbiters get the full clear window before the next race.
          eval_q      <= eval_nxt;
          launch_q    <= 1'b0;
          puf_reset_q <= 1'b1;
          if (eval_nxt < CntW'(NUM_EVALS)) begin
            state_q <= StArm;
          end else begin
            resp_valid_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PUF; i++) begin : g_vote
    pdl_vote_counter #(
      .NUM_EVALS(NUM_EVALS)
    ) u_vote (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .sample   (sample),
      .puf_o    (puf_o[i]),
      .majority (resp_bits[i]),
      .unstable (resp_unstable[i])
    );
  end

  assign chal_ready = (state_q == StIdle) && !reset;
  assign resp_valid = resp_valid_q;
  assign puf_s_tp   = s_tp_q;
  assign puf_s_btm  = s_btm_q;
  assign puf_launch = launch_q;
  assign puf_reset  = puf_reset_q;

endmodule

// File: tb/tb_pdl_puf_controller.sv
// Randomised bench for pdl_puf_controller against a per-eval vote-tally reference model.
module tb_pdl_puf_controller;

  localparam int NP  = 16;
  localparam int PW  = 64;
  localparam int NE  = 7;
  localparam int RC  = 2;
  localparam int SC  = 8;
  localparam int LAT = NE * (RC + SC + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          chal_valid = 1'b0;
  logic          chal_ready;
  logic [PW-1:0] chal_top = '0;
  logic [PW-1:0] chal_bottom = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [NP-1:0] resp_bits;
  logic [NP-1:0] resp_unstable;
  logic [PW-1:0] puf_s_tp;
  logic [PW-1:0] puf_s_btm;
  logic          puf_launch;
  logic          puf_reset;
  logic [NP-1:0] puf_o;

  // Single-eval, narrow instance
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_top = '0;
  logic [7:0] s_btm = '0;
  logic       s_rvalid;
  logic       s_rready = 1'b0;
  logic [3:0] s_bits;
  logic [3:0] s_unst;
  logic [7:0] s_tp_o;
  logic [7:0] s_btm_o;
  logic       s_launch;
  logic       s_preset;
  logic [3:0] s_puf_o = '0;

  int checks = 0;
  int failures = 0;

  logic [NP-1:0] pat [NE];
  int            launch_cnt = 0;
  int            base = 0;
  int            idx;
  logic [PW-1:0] cur_top, cur_btm, nxt_top, nxt_btm;

  always #5 clk = ~clk;

  // The modelled PUF changes its answer each time the race signal is withdrawn.
  always @(negedge puf_launch) launch_cnt = launch_cnt + 1;

  always_comb begin
    idx = launch_cnt - base;
    if (idx < 0 || idx >= NE) idx = NE - 1;
    puf_o = pat[idx];
  end

  pdl_puf_controller u_dut (
    .clk           (clk),
    .reset         (reset),
    .chal_valid    (chal_valid),
    .chal_ready    (chal_ready),
    .chal_top      (chal_top),
    .chal_bottom   (chal_bottom),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_bits     (resp_bits),
    .resp_unstable (resp_unstable),
    .puf_s_tp      (puf_s_tp),
    .puf_s_btm     (puf_s_btm),
    .puf_launch    (puf_launch),
    .puf_reset     (puf_reset),
    .puf_o         (puf_o)
  );

  pdl_puf_controller #(
    .NUM_PUF       (4),
    .PDL_WIDTH     (8),
    .NUM_EVALS     (1),
    .RESET_CYCLES  (2),
    .SETTLE_CYCLES (8)
  ) u_small (
    .clk           (clk),
    .reset         (reset),
    .chal_valid    (s_valid),
    .chal_ready    (s_ready),
    .chal_top      (s_top),
    .chal_bottom   (s_btm),
    .resp_valid    (s_rvalid),
    .resp_ready    (s_rready),
    .resp_bits     (s_bits),
    .resp_unstable (s_unst),
    .puf_s_tp      (s_tp_o),
    .puf_s_btm     (s_btm_o),
    .puf_launch    (s_launch),
    .puf_reset     (s_preset),
    .puf_o         (s_puf_o)
  );

  function automatic void model(output logic [NP-1:0] b, output logic [NP-1:0] u);
    for (int i = 0; i < NP; i++) begin
      int ones;
      ones = 0;
      for (int e = 0; e < NE; e++) ones += int'(pat[e][i]);
      b[i] = (2 * ones > NE);
      u[i] = (ones != 0) && (ones != NE);
    end
  endfunction

  function automatic logic [PW-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic randomize_pats();
    for (int e = 0; e < NE; e++) pat[e] = NP'($urandom());
  endtask

  task automatic start_challenge(input logic [PW-1:0] top, input logic [PW-1:0] btm);
    int n;
    n = 0;
    while (chal_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (chal_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_ready: chal_ready=%b required 1", chal_ready);
    end
    chal_valid = 1'b1;
    chal_top = top;
    chal_bottom = btm;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    base = launch_cnt;
    cur_top = top;
    cur_btm = btm;
    checks++;
    if (puf_s_tp !== top || puf_s_btm !== btm) begin
      failures++;
      $display("FAIL accept_cfg: s_tp=%h s_btm=%h required %h %h", puf_s_tp, puf_s_btm, top, btm);
    end
  endtask

  // Runs from one step after the acceptance edge to the DONE handshake.
  task automatic finish_challenge(input int hold, input bit pulse);
    int n, rst_hi, lau_hi, both_hi, cfg_bad, stable_bad;
    logic [NP-1:0] eb, eu;
    model(eb, eu);
    n = 0; rst_hi = 0; lau_hi = 0; both_hi = 0; cfg_bad = 0; stable_bad = 0;
    while (resp_valid !== 1'b1 && n <= LAT + 20) begin
      rst_hi += int'(puf_reset);
      lau_hi += int'(puf_launch);
      both_hi += int'(puf_reset && puf_launch);
      cfg_bad += int'(puf_s_tp !== cur_top || puf_s_btm !== cur_btm);
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != LAT) begin
      failures++;
      $display("FAIL latency: got %0d cycles required %0d", n, LAT);
    end
    checks++;
    if (rst_hi != NE * RC || lau_hi != NE * (SC + 1) || both_hi != 0) begin
      failures++;
      $display("FAIL waveform: reset_hi=%0d launch_hi=%0d both=%0d required %0d %0d 0",
               rst_hi, lau_hi, both_hi, NE * RC, NE * (SC + 1));
    end
    checks++;
    if (cfg_bad != 0) begin
      failures++;
      $display("FAIL cfg_stable: %0d cycles changed required 0", cfg_bad);
    end
    checks++;
    if (resp_bits !== eb || resp_unstable !== eu) begin
      failures++;
      $display("FAIL response: bits=%h unstable=%h required %h %h", resp_bits, resp_unstable, eb, eu);
    end
    checks++;
    if (chal_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_ready: chal_ready=%b required 0", chal_ready);
    end
    for (int k = 0; k < hold; k++) begin
      if (pulse && k == 2) begin
        chal_valid = 1'b1; chal_top = nxt_top; chal_bottom = nxt_btm;
      end else if (pulse && k == 3) begin
        chal_valid = 1'b0;
      end
      if (pulse && k >= hold - 3) begin
        chal_valid = 1'b1; chal_top = nxt_top; chal_bottom = nxt_btm;
      end
      @(posedge clk); #1;
      stable_bad += int'(resp_valid !== 1'b1 || resp_bits !== eb || resp_unstable !== eu ||
                         chal_ready !== 1'b0 || puf_s_tp !== cur_top || puf_s_btm !== cur_btm);
    end
    if (hold > 0) begin
      checks++;
      if (stable_bad != 0) begin
        failures++;
        $display("FAIL hold_stable: %0d disturbed cycles required 0", stable_bad);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || chal_ready !== 1'b1 || puf_s_tp !== cur_top) begin
      failures++;
      $display("FAIL release: resp_valid=%b chal_ready=%b s_tp=%h required 0 1 %h",
               resp_valid, chal_ready, puf_s_tp, cur_top);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (chal_ready !== 1'b0 || puf_launch !== 1'b0 || puf_reset !== 1'b1 || resp_valid !== 1'b0 ||
        resp_bits !== '0 || resp_unstable !== '0 || puf_s_tp !== '0 || puf_s_btm !== '0) begin
      failures++;
      $display("FAIL reset_state: ready=%b launch=%b preset=%b rvalid=%b bits=%h unst=%h tp=%h btm=%h",
               chal_ready, puf_launch, puf_reset, resp_valid, resp_bits, resp_unstable,
               puf_s_tp, puf_s_btm);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (chal_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: chal_ready=%b required 1", chal_ready);
    end
  endtask

  task automatic test_stable();
    for (int e = 0; e < NE; e++) pat[e] = 16'hA5C3;
    start_challenge({PW{1'b1}}, '0);
    finish_challenge(0, 1'b0);
  endtask

  task automatic test_vote_split();
    randomize_pats();
    for (int e = 0; e < NE; e++) begin
      pat[e][0] = (e == 0 || e == 2 || e == 4);
      pat[e][1] = (e < 4);
    end
    start_challenge(rand_word(), rand_word());
    finish_challenge(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    randomize_pats();
    nxt_top = rand_word();
    nxt_btm = rand_word();
    start_challenge(rand_word(), rand_word());
    finish_challenge(20, 1'b1);
    randomize_pats();
    start_challenge(nxt_top, nxt_btm);
    finish_challenge(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    randomize_pats();
    start_challenge(rand_word(), rand_word());
    n = 0;
    while (!(launch_cnt - base == 3 && puf_launch === 1'b1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL reach_eval3: timeout after %0d cycles", n);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (puf_launch !== 1'b0 || puf_reset !== 1'b1 || resp_valid !== 1'b0 || chal_ready !== 1'b0 ||
        resp_bits !== '0 || puf_s_tp !== '0) begin
      failures++;
      $display("FAIL mid_reset: launch=%b preset=%b rvalid=%b ready=%b bits=%h tp=%h required 0 1 0 0 0 0",
               puf_launch, puf_reset, resp_valid, chal_ready, resp_bits, puf_s_tp);
    end
    reset = 1'b0;
    #1;
    randomize_pats();
    start_challenge(rand_word(), rand_word());
    finish_challenge(0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      randomize_pats();
      start_challenge(rand_word(), rand_word());
      finish_challenge(int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_single_eval();
    for (int r = 0; r < 3; r++) begin
      int n;
      logic [7:0] t;
      s_puf_o = 4'($urandom());
      t = 8'($urandom());
      n = 0;
      while (s_ready !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      s_valid = 1'b1; s_top = t; s_btm = ~t;
      @(posedge clk); #1;
      s_valid = 1'b0;
      n = 0;
      while (s_rvalid !== 1'b1 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n != RC + SC + 1) begin
        failures++;
        $display("FAIL small_latency: got %0d required %0d", n, RC + SC + 1);
      end
      checks++;
      if (s_bits !== s_puf_o || s_unst !== 4'h0 || s_tp_o !== t || s_btm_o !== ~t) begin
        failures++;
        $display("FAIL small_resp: bits=%h unst=%h tp=%h required %h 0 %h", s_bits, s_unst, s_tp_o,
                 s_puf_o, t);
      end
      s_rready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0;
    end
  endtask

  initial begin
    for (int e = 0; e < NE; e++) pat[e] = '0;
    test_reset();
    test_stable();
    test_vote_split();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_single_eval();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
